// File: rtl/regfile_sequencer.sv
// Sequences single-register commands from two requesters onto the 8x16 register file.
// Optional PC write protection for port 1 is enabled by defining REGSEQ_PC_PROTECT_EN.
module regfile_sequencer #(
    parameter int NREQ = 2,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [AW*NREQ-1:0]   req_a,
    input  logic [AW*NREQ-1:0]   req_b,
    input  logic [DW*NREQ-1:0]   req_data,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [DW-1:0]        rsp_src,
    output logic [DW-1:0]        rsp_dst,
    output logic                 rsp_err,
    output logic [AW-1:0]        rf_src_sel,
    output logic [AW-1:0]        rf_dst_sel,
    output logic                 rf_out_en,
    output logic                 rf_in_en,
    output logic [DW-1:0]        rf_in,
    input  logic [DW-1:0]        rf_src,
    input  logic [DW-1:0]        rf_dst,
    output logic [2:0]           dbg_state
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADDI  = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    // Handshake: a command on port i transfers on the rising edge where
    // req_valid[i] and req_ready[i] are both 1; ready is only offered in IDLE
    // and never depends on anything but the current valids and last grant.

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   a_q, a_d;
    logic [AW-1:0]   b_q, b_d;
    logic [DW-1:0]   data_q, data_d;
    logic            id_q, id_d;
    logic            err_q, err_d;
    logic            last_grant_q, last_grant_d;
    logic [DW-1:0]   rsp_src_q, rsp_src_d;
    logic [DW-1:0]   rsp_dst_q, rsp_dst_d;

    logic            grant_valid;
    logic            grant_id;
    logic [1:0]      sel_op;
    logic [AW-1:0]   sel_a;
    logic [AW-1:0]   sel_b;
    logic [DW-1:0]   sel_data;
    logic            acc_err;

    // Round-robin between two ports: on contention the port not served last wins.
    always_comb begin
        grant_valid = |req_valid;
        if (req_valid[0] && req_valid[1]) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    always_comb begin
        if (grant_id) begin
            sel_op   = req_op[3:2];
            sel_a    = req_a[AW +: AW];
            sel_b    = req_b[AW +: AW];
            sel_data = req_data[DW +: DW];
        end else begin
            sel_op   = req_op[1:0];
            sel_a    = req_a[0 +: AW];
            sel_b    = req_b[0 +: AW];
            sel_data = req_data[0 +: DW];
        end
    end

`ifdef REGSEQ_PC_PROTECT_EN
    assign acc_err = grant_id && (sel_op != OP_READ) && (sel_b == '0);
`else
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_READ;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_src_q    <= '0;
            rsp_dst_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_q       <= data_d;
            id_q         <= id_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            rsp_src_q    <= rsp_src_d;
            rsp_dst_q    <= rsp_dst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        data_d       = data_q;
        id_d         = id_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        rsp_src_d    = rsp_src_q;
        rsp_dst_d    = rsp_dst_q;
        req_ready    = '0;
        rf_out_en    = 1'b0;
        rf_in_en     = 1'b0;
        rf_src_sel   = '0;
        rf_dst_sel   = '0;
        rf_in        = '0;
        rsp_valid    = 1'b0;
        rsp_id       = 1'b0;
        rsp_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    data_d       = sel_data;
                    id_d         = grant_id;
                    err_d        = acc_err;
                    last_grant_d = grant_id;
                    if (sel_op == OP_WRITE) begin
                        state_d = acc_err ? S_RSP : S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                rf_out_en  = 1'b1;
                rf_src_sel = a_q;
                rf_dst_sel = b_q;
                state_d    = S_CAP;
            end
            S_CAP: begin
                rsp_src_d = rf_src;
                rsp_dst_d = rf_dst;
                state_d   = (op_q == OP_READ) ? S_RSP : S_WR;
            end
            S_WR: begin
                // A rejected ADDI/MOVE still spends this cycle so its latency matches an accepted one.
                if (!err_q) begin
                    rf_in_en   = 1'b1;
                    rf_dst_sel = b_q;
                    case (op_q)
                        OP_WRITE: rf_in = data_q;
                        OP_ADDI:  rf_in = rsp_dst_q + data_q;
                        OP_MOVE:  rf_in = rsp_src_q;
                        default:  rf_in = '0;
                    endcase
                end
                state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_err   = err_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rsp_src   = rsp_src_q;
    assign rsp_dst   = rsp_dst_q;
    assign dbg_state = state_q;

endmodule
